ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 4: number of tracked key channels, 1..16.
REQ-002 The block SHALL have parameter KEY_CODES, default {8'h2B,8'h23,8'h1B,8'h1C}: NUM_KEYS*8 bits; byte i is the make code of channel i (ch0=1C a, ch1=1B s, ch2=23 d, ch3=2B f).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 50000: clk cycles without a PS/2 falling edge before a partial frame is aborted.
REQ-004 The block SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for the PS/2 inputs, minimum 2.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port PS2_CLOCK, input, 1 bit: asynchronous PS/2 device clock.
REQ-008 The block SHALL have port PS2_DATA, input, 1 bit: asynchronous PS/2 device data.
REQ-009 The block SHALL have port rxdata, output, 8 bits: the last good scan byte.
REQ-010 The block SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rxdata updates.
REQ-011 The block SHALL have port key_held, output, NUM_KEYS bits: level, 1 while channel i is pressed.
REQ-012 The block SHALL have port key_press, output, NUM_KEYS bits: one-cycle pulse on a 0->1 transition of key_held[i].
REQ-013 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-014 PS2_CLOCK and PS2_DATA SHALL pass through SYNC_STAGES flops; a falling edge is synchronised clock 1->0 and is registered as a one-cycle strobe.
REQ-015 The FSM SHALL have states IDLE, DATA, PARITY and STOP, and act only on strobe cycles, except for the timeout.
REQ-016 IDLE: on a strobe with data 0 (start bit), go to DATA with bit count 0; a strobe with data 1 stays in IDLE and is ignored.
REQ-017 DATA: shift the bit in LSB-first; after the 8th bit go to PARITY.
REQ-018 PARITY: capture the bit, then go to STOP.
REQ-019 STOP: a frame is good if the stop bit is 1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity); go to IDLE in either case.
REQ-020 A good frame SHALL load rxdata and pulse rx_valid one clk after the stop strobe.
REQ-021 A bad frame SHALL pulse frame_err instead; rxdata holds its value and no key state changes.
REQ-022 Timeout: a counter clears on every strobe and counts while the FSM is not IDLE; when it reaches TIMEOUT_CYCLES the FSM goes to IDLE and frame_err pulses; the counter saturates and never wraps.
REQ-023 Decoder: good byte F0 sets the brk flag; good byte E0 sets the ext flag; neither is a key event.
REQ-024 Decoder: any other good byte with ext=1 is discarded (extended keys are not mapped); brk and ext then clear.
REQ-025 Decoder: any other good byte with ext=0 that matches KEY_CODES[i] sets key_held[i] to !brk; brk and ext then clear.
REQ-026 Decoder: an unmatched byte changes no channel and clears brk and ext.
REQ-027 A repeated make code for a held key SHALL NOT pulse key_press again (typematic suppression).
REQ-028 If several KEY_CODES entries are equal, every matching channel SHALL update.
REQ-029 A frame_err SHALL clear brk and ext.

Reset
REQ-030 On reset the FSM SHALL go to IDLE and the bit count and timeout counter SHALL clear.
REQ-031 On reset rxdata SHALL be 8'h00 and key_held all-zero; rx_valid, key_press and frame_err SHALL be 0; brk and ext SHALL be 0.
REQ-032 On reset the synchroniser flops SHALL be 1 (idle bus), so no spurious edge follows reset.
REQ-033 Reset in mid-frame SHALL discard the partial frame; the next start bit is decoded normally.

Structure
REQ-034 Package ps2_pkg SHALL hold the FSM state enum and the constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0.
REQ-035 Sub-module ps2_sync_edge SHALL contain the synchroniser and the falling-edge strobe, and output synchronised data plus the strobe.

Verification
REQ-036 A good frame 1C with odd parity SHALL give rxdata=1C, one rx_valid pulse, key_held=0001 and a key_press[0] pulse.
REQ-037 The sequence 1C, 1C, F0, 1C SHALL give exactly one key_press[0], with key_held[0] going to 0 after the 4th byte.
REQ-038 The sequence E0, 1C SHALL leave key_held=0000 with two rx_valid pulses; a following 1B SHALL set key_held[1].
REQ-039 Byte 23 with a flipped parity bit SHALL give a frame_err pulse, no rx_valid and an unchanged key_held.
REQ-040 Stopping after 5 data bits for TIMEOUT_CYCLES SHALL give a frame_err pulse, FSM in IDLE, and a following 2B frame SHALL set key_held[3].
REQ-041 Reset asserted mid-frame while key_held=0011 SHALL clear all outputs, and the next 1C frame SHALL decode correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises PS/2 clock/data into clk and strobes each falling PS/2 clock edge.
// Latency: SYNC_STAGES+1 clk from pin edge to fall_stb; data_sync is aligned to the strobe.
// Backpressure: none; the PS/2 device cannot be stalled.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic PS2_CLOCK,
  input  logic PS2_DATA,
  output logic data_sync,
  output logic fall_stb
);

  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] dat_sr;
  logic                   clk_prev;

  // Flops reset to 1 (idle bus) so no falling edge is seen right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sr    <= '1;
      dat_sr    <= '1;
      clk_prev  <= 1'b1;
      fall_stb  <= 1'b0;
      data_sync <= 1'b1;
    end else begin
      clk_sr    <= {clk_sr[SYNC_STAGES-2:0], PS2_CLOCK};
      dat_sr    <= {dat_sr[SYNC_STAGES-2:0], PS2_DATA};
      clk_prev  <= clk_sr[SYNC_STAGES-1];
      fall_stb  <= clk_prev & ~clk_sr[SYNC_STAGES-1];
      data_sync <= dat_sr[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 frame receiver plus make/break decoder tracking NUM_KEYS key channels.
// Latency: rx_valid/frame_err/key_* update 1 clk after the stop-bit strobe.
// Backpressure: none; outputs are pulses/levels with no ready handshake.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int                      NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*8-1:0]   KEY_CODES      = {8'h2B, 8'h23, 8'h1B, 8'h1C},
  parameter int                      TIMEOUT_CYCLES = 50000,
  parameter int                      SYNC_STAGES    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                PS2_CLOCK,
  input  logic                PS2_DATA,
  output logic [7:0]          rxdata,
  output logic                rx_valid,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic                frame_err
);

  localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_MAX = TW'(TIMEOUT_CYCLES);

  logic                data_sync;
  logic                fall_stb;
  ps2_state_t          state, state_nxt;
  logic [2:0]          bit_cnt, bit_cnt_nxt;
  logic [7:0]          shreg, shreg_nxt;
  logic                par_bit, par_nxt;
  logic [TW-1:0]       tmo_cnt;
  logic                frame_good, frame_bad;
  logic                brk, ext;
  logic [NUM_KEYS-1:0] key_match, held_nxt;
  logic                is_key_byte;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .PS2_CLOCK (PS2_CLOCK),
    .PS2_DATA  (PS2_DATA),
    .data_sync (data_sync),
    .fall_stb  (fall_stb)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      par_bit <= par_nxt;
      if (fall_stb)
        tmo_cnt <= '0;
      else if (state != IDLE && tmo_cnt != TMO_MAX)
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_nxt     = par_bit;
    frame_good  = 1'b0;
    frame_bad   = 1'b0;
    if (fall_stb) begin
      case (state)
        IDLE: if (!data_sync) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
        end
        DATA: begin
          shreg_nxt   = {data_sync, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_nxt   = data_sync;
          state_nxt = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          // Odd parity: data bits plus parity bit must XOR to 1.
          if (data_sync && ((^shreg) ^ par_bit)) frame_good = 1'b1;
          else                                   frame_bad  = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE && tmo_cnt == TMO_MAX) begin
      state_nxt = IDLE;
      frame_bad = 1'b1;
    end
  end

  always_comb begin
    key_match   = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      key_match[i] = (shreg == KEY_CODES[i*8 +: 8]);
    is_key_byte = frame_good && shreg != PS2_BREAK && shreg != PS2_EXT;
    held_nxt    = key_held;
    // Extended-prefixed codes are never mapped to a channel.
    if (is_key_byte && !ext)
      held_nxt = (key_held & ~key_match) | (brk ? '0 : key_match);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rxdata    <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      key_held  <= '0;
      key_press <= '0;
      brk       <= 1'b0;
      ext       <= 1'b0;
    end else begin
      rx_valid  <= frame_good;
      frame_err <= frame_bad;
      key_held  <= held_nxt;
      key_press <= held_nxt & ~key_held;
      if (frame_good) rxdata <= shreg;
      if (frame_bad || is_key_byte) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (frame_good && shreg == PS2_BREAK) begin
        brk <= 1'b1;
      end else if (frame_good && shreg == PS2_EXT) begin
        ext <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench: each driven frame pushes its expected outcome; the monitor pops on rx_valid/frame_err.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  localparam int TMO  = 300;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       PS2_CLOCK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic [7:0] rxdata;
  logic       rx_valid;
  logic [3:0] key_held;
  logic [3:0] key_press;
  logic       frame_err;

  ps2_key_decoder #(
    .NUM_KEYS       (4),
    .KEY_CODES      ({8'h2B, 8'h23, 8'h1B, 8'h1C}),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .PS2_CLOCK (PS2_CLOCK),
    .PS2_DATA  (PS2_DATA),
    .rxdata    (rxdata),
    .rx_valid  (rx_valid),
    .key_held  (key_held),
    .key_press (key_press),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] dat;
    logic [3:0] held;
    logic [3:0] press;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e_mon;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] codes [4] = '{8'h1C, 8'h1B, 8'h23, 8'h2B};
  logic [3:0] m_held = '0;
  logic       m_brk = 1'b0;
  logic       m_ext = 1'b0;
  logic [7:0] m_last = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of the decoder, applied when a frame is queued.
  task automatic push_byte(input logic [7:0] b, input bit bad);
    exp_t       e;
    logic [3:0] old;
    old = m_held;
    if (bad) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else begin
      m_last = b;
      if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE0) m_ext = 1'b1;
      else begin
        if (!m_ext)
          for (int i = 0; i < 4; i++)
            if (b == codes[i]) m_held[i] = !m_brk;
        m_brk = 1'b0;
        m_ext = 1'b0;
      end
    end
    e.is_err = bad;
    e.dat    = m_last;
    e.held   = m_held;
    e.press  = m_held & ~old;
    exp_q.push_back(e);
  endtask

  task automatic ps2_bit(input logic v);
    PS2_DATA = v;
    repeat (HALF) @(posedge clk);
    PS2_CLOCK = 1'b0;
    repeat (HALF) @(posedge clk);
    PS2_CLOCK = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    push_byte(b, bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    PS2_DATA = 1'b1;
    repeat (HALF) @(posedge clk);
    drain();
  endtask

  task automatic check_reset_state(input string pfx);
    @(negedge clk);
    chk({pfx, "_rxdata"},    32'(rxdata),    32'h00);
    chk({pfx, "_key_held"},  32'(key_held),  32'h0);
    chk({pfx, "_rx_valid"},  32'(rx_valid),  32'h0);
    chk({pfx, "_key_press"}, 32'(key_press), 32'h0);
    chk({pfx, "_frame_err"}, 32'(frame_err), 32'h0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          e_mon = exp_q.pop_front();
          chk("rx_valid",  32'(rx_valid),  32'(!e_mon.is_err));
          chk("frame_err", 32'(frame_err), 32'(e_mon.is_err));
          chk("rxdata",    32'(rxdata),    32'(e_mon.dat));
          chk("key_held",  32'(key_held),  32'(e_mon.held));
          chk("key_press", 32'(key_press), 32'(e_mon.press));
        end
      end else if (key_press != 4'h0) begin
        chk("stray_press", 32'(key_press), 32'h0);
      end
    end
  end

  initial begin
    repeat (4) @(posedge clk);
    check_reset_state("rst");
    @(posedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    send_frame(8'h1C, 1'b0);                 // first make of channel 0
    send_frame(8'h1C, 1'b0);                 // typematic repeat
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);                 // release
    send_frame(8'hE0, 1'b0);
    send_frame(8'h1C, 1'b0);                 // extended, discarded
    send_frame(8'h1B, 1'b0);
    send_frame(8'h23, 1'b1);                 // parity error

    ps2_bit(1'b1);                           // idle-state edge with data high
    repeat (HALF) @(posedge clk);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h55, 1'b0);                 // unmatched byte clears brk
    send_frame(8'h1B, 1'b0);

    push_byte(8'h00, 1'b1);                  // timeout after 5 data bits
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    repeat (TMO + 40) @(posedge clk);
    drain();
    chk("fsm_idle", 32'(dut.state), 32'(IDLE));
    send_frame(8'h2B, 1'b0);

    send_frame(8'hF0, 1'b0);
    send_frame(8'h2B, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1B, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'h1B, 1'b0);
    chk("held_0011", 32'(key_held), 32'h3);

    ps2_bit(1'b0);                           // partial frame, then reset
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(posedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    check_reset_state("midrst");
    chk("midrst_fsm", 32'(dut.state), 32'(IDLE));
    m_held = '0;
    m_brk  = 1'b0;
    m_ext  = 1'b0;
    m_last = 8'h00;
    @(posedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    send_frame(8'h1C, 1'b0);
    chk("final_held", 32'(key_held), 32'h1);

    repeat (20) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
